// File: rtl/convround_pkg.sv
// Shared types and width helpers for the convergent-rounding scheduler.
// Result width is half the word width; the ID is wide enough for every requester.
package convround_pkg;

    function automatic int res_width(int w);
        return w / 2;
    endfunction

    function automatic int id_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/convround_rr_sched_if.sv
// Request/result bundle between the producers, the scheduler and the sink.
// slave is the scheduler's view, master is the environment's view.
interface convround_rr_sched_if
    import convround_pkg::*;
#(
    parameter int p_WORD_WIDTH = 8,
    parameter int p_NUM_REQ    = 4
);
    logic [p_NUM_REQ-1:0]              req_valid;
    logic [p_NUM_REQ-1:0]              req_ready;
    logic [p_NUM_REQ*p_WORD_WIDTH-1:0] req_data;
    logic                              res_valid;
    logic                              res_ready;
    logic [res_width(p_WORD_WIDTH)-1:0] res_data;
    logic [id_width(p_NUM_REQ)-1:0]    res_id;
    logic                              res_ovf;

    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_data, res_id, res_ovf
    );

    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_data, res_id, res_ovf
    );
endinterface

// File: rtl/convround_core.sv
// Round-half-to-even of the upper half of a word; flags carry-out as ovf.
// CONVROUND_RR_SAT_EN: saturate to all ones on carry-out instead of wrapping.
module convround_core
    import convround_pkg::*;
#(
    parameter int p_WORD_WIDTH = 8
) (
    input  logic [p_WORD_WIDTH-1:0]             din,
    output logic [res_width(p_WORD_WIDTH)-1:0]  dout,
    output logic                                ovf
);
    localparam int LSB = p_WORD_WIDTH / 2;

    logic [LSB-1:0] hi;
    logic [LSB-1:0] sum;
    logic           guard;
    logic           sticky;
    logic           round_up;

    assign hi       = din[p_WORD_WIDTH-1:LSB];
    assign guard    = din[LSB-1];
    assign sticky   = |din[LSB-2:0];
    // Exact half rounds toward the even neighbour (hi[0] is the parity).
    assign round_up = guard & (hi[0] | sticky);
    assign sum      = hi + {{(LSB-1){1'b0}}, round_up};
    assign ovf      = round_up & (&hi);

`ifdef CONVROUND_RR_SAT_EN
    assign dout = ovf ? '1 : sum;
`else
    assign dout = sum;
`endif

endmodule

// File: rtl/convround_rr_sched.sv
// Round-robin sharing of one rounding datapath with a registered result.
// Optional saturation via CONVROUND_RR_SAT_EN (handled in convround_core).
module convround_rr_sched
    import convround_pkg::*;
#(
    parameter int p_WORD_WIDTH = 8,
    parameter int p_NUM_REQ    = 4
) (
    input logic                i_CLK,
    input logic                i_RST,
    convround_rr_sched_if.slave bus
);
    localparam int RW = res_width(p_WORD_WIDTH);
    localparam int IW = id_width(p_NUM_REQ);

    state_t                  state_q;
    state_t                  state_d;
    logic [IW-1:0]           ptr_q;
    logic [IW-1:0]           ptr_nxt;
    logic [IW-1:0]           gnt_idx;
    logic [IW-1:0]           cand;
    int                      k;
    logic                    found;
    logic                    can_issue;
    logic                    xfer;
    logic [p_WORD_WIDTH-1:0] word;
    logic [RW-1:0]           rnd;
    logic                    rnd_ovf;
    logic [RW-1:0]           data_q;
    logic [IW-1:0]           id_q;
    logic                    ovf_q;

    // Search upward from the pointer, wrapping, for the first valid requester.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        k       = 0;
        cand    = '0;
        for (int i = 0; i < p_NUM_REQ; i++) begin
            k = int'(ptr_q) + i;
            if (k >= p_NUM_REQ) k = k - p_NUM_REQ;
            cand = IW'(k);
            if (!found && bus.req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // No grant during reset or while a held result is not being drained.
    assign can_issue = !i_RST && ((state_q == EMPTY) || bus.res_ready);
    assign xfer      = can_issue && found;
    assign ptr_nxt   = (gnt_idx == IW'(p_NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign word      = bus.req_data[gnt_idx*p_WORD_WIDTH +: p_WORD_WIDTH];

    // One-hot ready for the granted requester, only when it transfers.
    always_comb begin
        bus.req_ready = '0;
        if (xfer) bus.req_ready[gnt_idx] = 1'b1;
    end

    convround_core #(
        .p_WORD_WIDTH (p_WORD_WIDTH)
    ) u_core (
        .din  (word),
        .dout (rnd),
        .ovf  (rnd_ovf)
    );

    // Result register occupancy: fill on transfer, empty when drained.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (xfer) state_d = FULL;
            FULL:  if (bus.res_ready && !xfer) state_d = EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    // Result payload and RR pointer advance only on a transfer.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            data_q <= '0;
            id_q   <= '0;
            ovf_q  <= 1'b0;
            ptr_q  <= '0;
        end else if (xfer) begin
            data_q <= rnd;
            id_q   <= gnt_idx;
            ovf_q  <= rnd_ovf;
            ptr_q  <= ptr_nxt;
        end
    end

    assign bus.res_valid = (state_q == FULL);
    assign bus.res_data  = data_q;
    assign bus.res_id    = id_q;
    assign bus.res_ovf   = ovf_q;

endmodule

// File: tb/tb_convround_rr_sched.sv
// Bench for convround_rr_sched (W=8, N=4): directed cases plus random traffic
// checked every cycle against an arithmetic round-robin/rounding model.
module tb_convround_rr_sched;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int RW = W / 2;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    int   m_valid;
    int   m_ptr;
    int   m_data;
    int   m_id;
    int   m_ovf;

    convround_rr_sched_if #(.p_WORD_WIDTH(W), .p_NUM_REQ(N)) bus ();

    convround_rr_sched #(
        .p_WORD_WIDTH (W),
        .p_NUM_REQ    (N)
    ) dut (
        .i_CLK (clk),
        .i_RST (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // First valid index at or after p, wrapping; -1 when none.
    function automatic int pick(int p, logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    // Returns ovf in bit RW and the rounded value below it.
    function automatic int rnd_model(int v);
        int hi, lo, half, up, r, o;
        hi   = v / (1 << RW);
        lo   = v % (1 << RW);
        half = 1 << (RW - 1);
        up   = (lo > half || (lo == half && hi % 2 == 1)) ? 1 : 0;
        r    = hi + up;
        o    = (r == (1 << RW)) ? 1 : 0;
        if (o == 1) begin
`ifdef CONVROUND_RR_SAT_EN
            r = (1 << RW) - 1;
`else
            r = 0;
`endif
        end
        return (o << RW) | r;
    endfunction

    function automatic int lane(logic [N*W-1:0] d, int g);
        return int'((d >> (W * g)) & ((1 << W) - 1));
    endfunction

    // Reference model update on each clock edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 0;
            m_ptr   <= 0;
            m_data  <= 0;
            m_id    <= 0;
            m_ovf   <= 0;
        end else if ((m_valid == 0 || bus.res_ready)
                     && pick(m_ptr, bus.req_valid) >= 0) begin
            m_valid <= 1;
            m_id    <= pick(m_ptr, bus.req_valid);
            m_data  <= rnd_model(lane(bus.req_data,
                         pick(m_ptr, bus.req_valid))) % (1 << RW);
            m_ovf   <= rnd_model(lane(bus.req_data,
                         pick(m_ptr, bus.req_valid))) >> RW;
            m_ptr   <= (pick(m_ptr, bus.req_valid) + 1) % N;
        end else if (bus.res_ready) begin
            m_valid <= 0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready", bus.req_ready, 0);
            chk("rst_valid", bus.res_valid, 0);
            chk("rst_data",  bus.res_data, 0);
            chk("rst_id",    bus.res_id, 0);
            chk("rst_ovf",   bus.res_ovf, 0);
        end else begin
            if ((m_valid == 0 || bus.res_ready)
                && pick(m_ptr, bus.req_valid) >= 0)
                chk("m_ready", bus.req_ready,
                    32'(1) << pick(m_ptr, bus.req_valid));
            else
                chk("m_ready", bus.req_ready, 0);
            chk("m_valid", bus.res_valid, m_valid);
            chk("m_data",  bus.res_data, m_data);
            chk("m_id",    bus.res_id, m_id);
            chk("m_ovf",   bus.res_ovf, m_ovf);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] vals [5];
    int         expd [5];
    int         expo [5];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        bus.req_valid = '1;
        bus.req_data  = '0;
        bus.res_ready = 1'b0;

        vals[0] = 8'h28; expd[0] = 2; expo[0] = 0;
        vals[1] = 8'h38; expd[1] = 4; expo[1] = 0;
        vals[2] = 8'h29; expd[2] = 3; expo[2] = 0;
        vals[3] = 8'h27; expd[3] = 2; expo[3] = 0;
        vals[4] = 8'hF8; expo[4] = 1;
`ifdef CONVROUND_RR_SAT_EN
        expd[4] = 15;
`else
        expd[4] = 0;
`endif

        @(negedge clk);
        chk("reset_ready", bus.req_ready, 0);
        chk("reset_valid", bus.res_valid, 0);
        cyc();
        cyc();
        rst = 1'b0;
        bus.req_valid = '0;
        bus.res_ready = 1'b1;

        for (int i = 0; i < 5; i++) begin
            bus.req_valid = 4'b0001;
            bus.req_data  = {24'h0, vals[i]};
            @(negedge clk);
            chk("rnd_grant", bus.req_ready, 4'b0001);
            cyc();
            bus.req_valid = '0;
            @(negedge clk);
            chk("rnd_data",  bus.res_data, expd[i]);
            chk("rnd_id",    bus.res_id, 0);
            chk("rnd_ovf",   bus.res_ovf, expo[i]);
            chk("rnd_valid", bus.res_valid, 1);
        end

        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_data  = 32'h44332211;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (i == 5) bus.res_ready = 1'b0;
            @(negedge clk);
            chk("fair_id", bus.res_id, i % 4);
        end

        for (int j = 0; j < 5; j++) begin
            cyc();
            @(negedge clk);
            chk("bp_ready", bus.req_ready, 0);
            chk("bp_valid", bus.res_valid, 1);
            chk("bp_id",    bus.res_id, 1);
            chk("bp_data",  bus.res_data, 2);
        end
        cyc();
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("bp_resume", bus.req_ready, 4'b0100);
        cyc();
        bus.req_valid = '0;
        @(negedge clk);
        chk("bp_id2",   bus.res_id, 2);
        chk("bp_data2", bus.res_data, 3);

        cyc();
        bus.req_valid = 4'b0100;
        bus.req_data  = 32'h005A6800;
        @(negedge clk);
        chk("sp_gnt2", bus.req_ready, 4'b0100);
        cyc();
        bus.req_valid = 4'b0010;
        @(negedge clk);
        chk("sp_gnt1", bus.req_ready, 4'b0010);
        chk("sp_id2",  bus.res_id, 2);
        chk("sp_d2",   bus.res_data, 6);
        cyc();
        bus.req_valid = 4'b1111;
        @(negedge clk);
        chk("sp_id1",  bus.res_id, 1);
        chk("sp_d1",   bus.res_data, 6);
        chk("sp_ptr2", bus.req_ready, 4'b0100);

        cyc();
        bus.res_ready = 1'b0;
        cyc();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", bus.res_valid, 0);
        chk("arst_ready", bus.req_ready, 0);
        cyc();
        cyc();
        rst = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("arst_gnt0", bus.req_ready, 4'b0001);
        cyc();
        @(negedge clk);
        chk("arst_id0", bus.res_id, 0);

        for (int c = 0; c < 3000; c++) begin
            cyc();
            rst = ($urandom_range(0, 299) == 0);
            if (c % 1000 < 500)
                bus.req_valid = 4'($urandom);
            else
                bus.req_valid = 4'($urandom & $urandom);
            bus.req_data = 32'($urandom);
            for (int q = 0; q < N; q++) begin
                if ($urandom_range(0, 3) == 0)
                    bus.req_data[q*W +: 4] = 4'h8;
                if ($urandom_range(0, 5) == 0)
                    bus.req_data[q*W+4 +: 4] = 4'hF;
            end
            bus.res_ready = ($urandom_range(0, 3) != 0);
        end
        cyc();
        rst = 1'b0;
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        cyc();
        cyc();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
